// File: rtl/sap_controller_if.sv
// Control-word bundle between the SAP sequencer and its datapath.
// The master side is the sequencer; the slave side is the datapath or a bench.
interface sap_controller_if;
    logic       Run;
    logic [7:0] Instruction;
    logic [1:0] Flags;
    logic       PcOut, PcInc, PcLoad;
    logic       MarLoad;
    logic       RamOut, RamLoad;
    logic       IrLoad, IrOut;
    logic       AccLoad, AccOut;
    logic       BLoad;
    logic [1:0] AluOp;
    logic       AluStart, AluOut;
    logic       FlagLoad;
    logic       OutLoad;
    logic       ZeroFlag, CarryFlag;
    logic       Halted;

    modport master (
        input  Run, Instruction, Flags,
        output PcOut, PcInc, PcLoad, MarLoad, RamOut, RamLoad, IrLoad, IrOut,
               AccLoad, AccOut, BLoad, AluOp, AluStart, AluOut, FlagLoad,
               OutLoad, ZeroFlag, CarryFlag, Halted
    );

    modport slave (
        output Run, Instruction, Flags,
        input  PcOut, PcInc, PcLoad, MarLoad, RamOut, RamLoad, IrLoad, IrOut,
               AccLoad, AccOut, BLoad, AluOp, AluStart, AluOut, FlagLoad,
               OutLoad, ZeroFlag, CarryFlag, Halted
    );
endinterface

// File: rtl/sap_controller.sv
// Microcoded SAP sequencer: T0..T4 step counter plus sticky HALT state,
// Moore control word gated by Run, and latched Zero/Carry flags.
module sap_controller (
    input  logic              clk,
    input  logic              rst_n,
    sap_controller_if.master  bus
);
    typedef enum logic [2:0] {
        T0   = 3'd0,
        T1   = 3'd1,
        T2   = 3'd2,
        T3   = 3'd3,
        T4   = 3'd4,
        HALT = 3'd5
    } step_t;

    typedef struct packed {
        logic       pc_out;
        logic       pc_inc;
        logic       pc_load;
        logic       mar_load;
        logic       ram_out;
        logic       ram_load;
        logic       ir_load;
        logic       ir_out;
        logic       acc_load;
        logic       acc_out;
        logic       b_load;
        logic [1:0] alu_op;
        logic       alu_start;
        logic       alu_out;
        logic       flag_load;
        logic       out_load;
    } ctrl_t;

    localparam logic [3:0] OP_NOP = 4'h0, OP_LDA = 4'h1, OP_ADD = 4'h2,
                           OP_SUB = 4'h3, OP_STA = 4'h4, OP_LDI = 4'h5,
                           OP_JMP = 4'h6, OP_JC  = 4'h7, OP_JZ  = 4'h8,
                           OP_INC = 4'h9, OP_DCR = 4'hA, OP_OUT = 4'hE,
                           OP_HLT = 4'hF;

    localparam logic [1:0] ALU_ADD = 2'b00, ALU_SUB = 2'b01,
                           ALU_INC = 2'b10, ALU_DCR = 2'b11;

    step_t      step, step_nxt;
    ctrl_t      word, word_g;
    logic       zero_q, carry_q;
    logic [3:0] opcode;

    assign opcode = bus.Instruction[7:4];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       step <= T0;
        else if (bus.Run) step <= step_nxt;
    end

    // word_g already carries the Run gate, so a frozen FlagLoad cycle captures nothing
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            zero_q  <= 1'b0;
            carry_q <= 1'b0;
        end else if (word_g.flag_load) begin
            zero_q  <= bus.Flags[1];
            carry_q <= bus.Flags[0];
        end
    end

    always_comb begin
        step_nxt = step;
        case (step)
            T0: step_nxt = T1;
            T1: step_nxt = T2;
            T2: begin
                case (opcode)
                    OP_LDA, OP_ADD, OP_SUB, OP_STA: step_nxt = T3;
                    OP_HLT:                         step_nxt = HALT;
                    default:                        step_nxt = T0;
                endcase
            end
            T3: step_nxt = (opcode == OP_ADD || opcode == OP_SUB) ? T4 : T0;
            T4: step_nxt = T0;
            HALT: step_nxt = HALT;
            default: step_nxt = T0;
        endcase
    end

    always_comb begin
        word = '0;
        case (step)
            T0: begin
                word.pc_out   = 1'b1;
                word.mar_load = 1'b1;
            end
            T1: begin
                word.ram_out = 1'b1;
                word.ir_load = 1'b1;
                word.pc_inc  = 1'b1;
            end
            T2: begin
                case (opcode)
                    OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
                        word.ir_out   = 1'b1;
                        word.mar_load = 1'b1;
                    end
                    OP_LDI: begin
                        word.ir_out   = 1'b1;
                        word.acc_load = 1'b1;
                    end
                    OP_JMP: begin
                        word.ir_out  = 1'b1;
                        word.pc_load = 1'b1;
                    end
                    // Conditional jumps look only at the latched flags
                    OP_JC: begin
                        word.ir_out  = carry_q;
                        word.pc_load = carry_q;
                    end
                    OP_JZ: begin
                        word.ir_out  = zero_q;
                        word.pc_load = zero_q;
                    end
                    OP_INC, OP_DCR: begin
                        word.alu_op    = (opcode == OP_INC) ? ALU_INC : ALU_DCR;
                        word.alu_start = 1'b1;
                        word.alu_out   = 1'b1;
                        word.acc_load  = 1'b1;
                        word.flag_load = 1'b1;
                    end
                    OP_OUT: begin
                        word.acc_out  = 1'b1;
                        word.out_load = 1'b1;
                    end
                    default: word = '0;
                endcase
            end
            T3: begin
                case (opcode)
                    OP_LDA: begin
                        word.ram_out  = 1'b1;
                        word.acc_load = 1'b1;
                    end
                    OP_ADD, OP_SUB: begin
                        word.ram_out = 1'b1;
                        word.b_load  = 1'b1;
                    end
                    OP_STA: begin
                        word.acc_out  = 1'b1;
                        word.ram_load = 1'b1;
                    end
                    default: word = '0;
                endcase
            end
            T4: begin
                if (opcode == OP_ADD || opcode == OP_SUB) begin
                    word.alu_op    = (opcode == OP_SUB) ? ALU_SUB : ALU_ADD;
                    word.alu_start = 1'b1;
                    word.alu_out   = 1'b1;
                    word.acc_load  = 1'b1;
                    word.flag_load = 1'b1;
                end
            end
            default: word = '0;
        endcase
    end

    assign word_g = (bus.Run && step != HALT) ? word : '0;

    assign bus.PcOut     = word_g.pc_out;
    assign bus.PcInc     = word_g.pc_inc;
    assign bus.PcLoad    = word_g.pc_load;
    assign bus.MarLoad   = word_g.mar_load;
    assign bus.RamOut    = word_g.ram_out;
    assign bus.RamLoad   = word_g.ram_load;
    assign bus.IrLoad    = word_g.ir_load;
    assign bus.IrOut     = word_g.ir_out;
    assign bus.AccLoad   = word_g.acc_load;
    assign bus.AccOut    = word_g.acc_out;
    assign bus.BLoad     = word_g.b_load;
    assign bus.AluOp     = word_g.alu_op;
    assign bus.AluStart  = word_g.alu_start;
    assign bus.AluOut    = word_g.alu_out;
    assign bus.FlagLoad  = word_g.flag_load;
    assign bus.OutLoad   = word_g.out_load;
    assign bus.ZeroFlag  = zero_q;
    assign bus.CarryFlag = carry_q;
    assign bus.Halted    = (step == HALT);

    logic unused_ok;
    assign unused_ok = (opcode == OP_NOP) ^ (^bus.Instruction[3:0]);
endmodule

// File: tb/tb_sap_controller.sv
// Directed bench for sap_controller: hand-computed control words per T-state,
// flag latching, Run freeze, HALT and reset, plus bus-exclusivity on every cycle.
module tb_sap_controller;
    logic clk = 1'b0;
    logic rst_n;
    int   passed = 0;
    int   total  = 0;

    sap_controller_if sif ();

    sap_controller dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (sif)
    );

    always #5 clk = ~clk;

    // {PcOut,PcInc,PcLoad,MarLoad,RamOut,RamLoad,IrLoad,IrOut,
    //  AccLoad,AccOut,BLoad,AluOp[1:0],AluStart,AluOut,FlagLoad,OutLoad}
    localparam logic [16:0] PCOUT = 17'h10000, PCINC = 17'h08000, PCLOAD  = 17'h04000,
                            MARLD = 17'h02000, RAMOUT = 17'h01000, RAMLD  = 17'h00800,
                            IRLD  = 17'h00400, IROUT  = 17'h00200, ACCLD  = 17'h00100,
                            ACCOUT = 17'h00080, BLD   = 17'h00040, OPSUB  = 17'h00010,
                            OPINC = 17'h00020, OPDCR  = 17'h00030, ALUST  = 17'h00008,
                            ALUOUT = 17'h00004, FLGLD = 17'h00002, OUTLD  = 17'h00001;
    localparam logic [16:0] W_T0   = PCOUT | MARLD;
    localparam logic [16:0] W_T1   = RAMOUT | IRLD | PCINC;
    localparam logic [16:0] W_ADDR = IROUT | MARLD;
    localparam logic [16:0] W_JMP  = IROUT | PCLOAD;
    localparam logic [16:0] W_ALU  = ALUST | ALUOUT | ACCLD | FLGLD;

    logic [16:0] cw;
    assign cw = {sif.PcOut, sif.PcInc, sif.PcLoad, sif.MarLoad, sif.RamOut, sif.RamLoad,
                 sif.IrLoad, sif.IrOut, sif.AccLoad, sif.AccOut, sif.BLoad, sif.AluOp,
                 sif.AluStart, sif.AluOut, sif.FlagLoad, sif.OutLoad};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) $display("FAIL %s: got %h expected %h", tag, obs, exp);
        else             passed++;
    endtask

    // check this cycle's word, then move to just after the next rising edge
    task automatic cyc(input string tag, input logic [16:0] exp);
        #1;
        chk(tag, {15'd0, cw}, {15'd0, exp});
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input string tag, input logic [7:0] ins);
        sif.Instruction = ins;
        cyc({tag, "_t0"}, W_T0);
        cyc({tag, "_t1"}, W_T1);
    endtask

    task automatic flags(input string tag, input logic z, input logic c);
        chk({tag, "_zero"},  {31'd0, sif.ZeroFlag},  {31'd0, z});
        chk({tag, "_carry"}, {31'd0, sif.CarryFlag}, {31'd0, c});
    endtask

    always @(negedge clk) begin
        chk("bus_excl", {31'd0, ($countones({sif.PcOut, sif.RamOut, sif.IrOut,
                                              sif.AccOut, sif.AluOut}) <= 1)}, 32'd1);
        chk("aluop_idle", {31'd0, (!sif.AluStart && sif.AluOp != 2'b00)}, 32'd0);
    end

    initial begin
        rst_n = 1'b0;
        sif.Run = 1'b1;
        sif.Instruction = 8'h00;
        sif.Flags = 2'b00;
        #3;
        chk("rst_run_word", {15'd0, cw}, {15'd0, W_T0});
        sif.Run = 1'b0;
        #1;
        chk("rst_norun_word", {15'd0, cw}, 32'd0);
        chk("rst_halted", {31'd0, sif.Halted}, 32'd0);
        flags("rst", 1'b0, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        sif.Run = 1'b1;

        fetch("nop", 8'h00);
        cyc("nop_t2", '0);

        sif.Flags = 2'b01;
        fetch("add", 8'h2A);
        cyc("add_t2", W_ADDR);
        cyc("add_t3", RAMOUT | BLD);
        cyc("add_t4", W_ALU);
        flags("add", 1'b0, 1'b1);

        sif.Flags = 2'b00;
        fetch("jc1", 8'h70);
        cyc("jc1_t2", W_JMP);

        sif.Flags = 2'b10;
        fetch("dcr", 8'hA0);
        cyc("dcr_t2", W_ALU | OPDCR);
        flags("dcr", 1'b1, 1'b0);

        sif.Flags = 2'b00;
        fetch("jz1", 8'h85);
        cyc("jz1_t2", W_JMP);
        fetch("jc0", 8'h70);
        cyc("jc0_t2", '0);

        fetch("inc", 8'h90);
        cyc("inc_t2", W_ALU | OPINC);
        flags("inc", 1'b0, 1'b0);
        fetch("jz0", 8'h85);
        cyc("jz0_t2", '0);

        fetch("lda", 8'h1F);
        cyc("lda_t2", W_ADDR);
        cyc("lda_t3", RAMOUT | ACCLD);
        fetch("sta", 8'h4E);
        cyc("sta_t2", W_ADDR);
        cyc("sta_t3", ACCOUT | RAMLD);
        fetch("ldi", 8'h55);
        cyc("ldi_t2", IROUT | ACCLD);
        fetch("jmp", 8'h63);
        cyc("jmp_t2", W_JMP);
        fetch("out", 8'hE0);
        cyc("out_t2", ACCOUT | OUTLD);
        fetch("undef", 8'hB0);
        cyc("undef_t2", '0);

        // SUB frozen for two cycles at T3
        sif.Flags = 2'b01;
        fetch("sub", 8'h31);
        cyc("sub_t2", W_ADDR);
        sif.Run = 1'b0;
        cyc("sub_frz0", '0);
        cyc("sub_frz1", '0);
        sif.Run = 1'b1;
        cyc("sub_t3", RAMOUT | BLD);
        cyc("sub_t4", W_ALU | OPSUB);
        flags("sub", 1'b0, 1'b1);

        // Run low in the FlagLoad cycle must not capture
        sif.Flags = 2'b10;
        fetch("incfrz", 8'h90);
        sif.Run = 1'b0;
        cyc("incfrz_frz", '0);
        flags("incfrz_hold", 1'b0, 1'b1);
        sif.Run = 1'b1;
        cyc("incfrz_t2", W_ALU | OPINC);
        flags("incfrz_cap", 1'b1, 1'b0);

        // reset in the middle of an ADD restarts at fetch
        sif.Flags = 2'b00;
        fetch("addrst", 8'h2A);
        cyc("addrst_t2", W_ADDR);
        cyc("addrst_t3", RAMOUT | BLD);
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        flags("addrst", 1'b0, 1'b0);
        cyc("addrst_restart", W_T0);
        cyc("addrst_t1", W_T1);
        sif.Instruction = 8'h00;
        cyc("addrst_nop_t2", '0);

        fetch("hlt", 8'hF0);
        chk("hlt_t2_halted", {31'd0, sif.Halted}, 32'd0);
        cyc("hlt_t2", '0);
        for (int i = 0; i < 12; i++) begin
            chk("hlt_halted", {31'd0, sif.Halted}, 32'd1);
            sif.Instruction = 8'h25;
            cyc("hlt_word", '0);
        end
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        chk("hlt_cleared", {31'd0, sif.Halted}, 32'd0);
        cyc("hlt_restart", W_T0);

        for (int i = 0; i < 200; i++) begin
            sif.Instruction = {4'($urandom_range(0, 14)), 4'($urandom)};
            sif.Run = ($urandom_range(0, 3) != 0);
            sif.Flags = 2'($urandom);
            @(posedge clk);
            #1;
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
